// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, one full-subtractor step per clock, LSB first.
// A start/busy/done handshake frames each WIDTH-cycle operation, and the result flags are held between completions.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             Z
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             bor_q, bor_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;
    logic             z_q, z_d;

    logic             diff_bit;
    logic             bor_next;
    logic [WIDTH-1:0] r_next;

    // One full-subtractor cell working on the current LSBs.
    assign diff_bit = a_sh_q[0] ^ b_sh_q[0] ^ bor_q;
    assign bor_next = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & bor_q);
    assign r_next   = {diff_bit, r_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_d     = r_q;
        bor_d   = bor_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        bout_d  = bout_q;
        v_d     = v_q;
        z_d     = z_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    bor_d   = Bin;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                r_d    = r_next;
                bor_d  = bor_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // On the MSB step bor_q is the borrow into the sign cell.
                    d_d     = r_next;
                    bout_d  = bor_next;
                    v_d     = bor_q ^ bor_next;
                    z_d     = (r_next == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_q     <= '0;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_q     <= r_d;
            bor_q   <= bor_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
            z_q     <= z_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign D    = d_q;
    assign Bout = bout_q;
    assign V    = v_q;
    assign Z    = z_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, multi-cycle subtractor: computes D = A − B − Bin one bit per clock, LSB first, with borrow-out, signed-overflow and zero flags. It is the inverse-direction companion to the team's 4-bit carry-lookahead adder. It trades the adder's single-cycle parallel logic for one full-subtractor cell plus shift registers, under a start/busy/done handshake. Sits beside the adder in the datapath experiments; results are directly comparable with {Cout, S} from the adder.

## Interface
- WIDTH, 4, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  reset, asynchronous and active-high
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  minuend, captured on the accepting edge
- B  input  WIDTH  subtrahend, captured on the accepting edge
- Bin  input  1  borrow-in, captured on the accepting edge
- busy  output  1  high while bits are being processed (SHIFT)
- done  output  1  one-cycle pulse; result valid and updated
- D  output  WIDTH  difference, held until next completion
- Bout  output  1  borrow out of MSB (1 = unsigned A < B + Bin)
- V  output  1  two's-complement overflow of A − B − Bin
- Z  output  1  1 when D == 0

## Operation
- States: IDLE, SHIFT, DONE. Reset forces IDLE.
- IDLE, start=1 at an edge:
  - load a_sh←A, b_sh←B, bor←Bin, cnt←0
  - go SHIFT
- IDLE, start=0: stay.
- SHIFT, each edge:
  - d = a_sh[0]^b_sh[0]^bor
  - bor ← (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&bor)
  - d shifts into MSB of result register r; a_sh, b_sh shift right; cnt++
  - record the borrow into the MSB cell (bor before the last step) as b_msb_in
- On the WIDTH-th SHIFT edge:
  - D ← final r, Bout ← final bor, V ← b_msb_in ^ final bor, Z ← (final r == 0)
  - go DONE
- DONE: done=1 for exactly this cycle; next edge → IDLE unconditionally.
- start is ignored in SHIFT and DONE; no queuing. Operand changes after capture have no effect.
- cnt width is clog2(WIDTH)+1; no wrap before terminal count.
- Arithmetic is modulo 2^WIDTH. {Bout, D} equals the (WIDTH+1)-bit two's-complement of A − B − Bin, matching the adder's {Cout, S} convention.

## Timing
- Reset (async, immediate, regardless of state): state=IDLE, busy=0, done=0, D=0, Bout=0, V=0, Z=0, internal shift regs/cnt=0.
- Reset mid-SHIFT aborts the operation. D/Bout/V/Z clear to 0 and no done pulse occurs.
- Latency: start accepted at edge 0. busy=1 from edge 0 to edge WIDTH. D/Bout/V/Z update at edge WIDTH. done=1 from edge WIDTH to edge WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. Earliest restart is start high in the cycle after done, accepted at edge WIDTH+2.
- busy and done are never high together. Both are registered, with no combinational path from inputs.
- D/Bout/V/Z change only at the completion edge or reset. They are stable at all other times.
- Back-to-back: start held continuously high → a new operation every WIDTH+2 cycles, each with its own operands sampled at its accepting edge.

## Test plan
- Reset: assert rst mid-cycle with clk idle → all outputs 0 immediately; deassert, start held 0 → stays IDLE, busy=0.
- A=5, B=3, Bin=0 → after 4 SHIFT cycles done pulses once; D=0010, Bout=0, V=0, Z=0; busy high exactly 4 cycles.
- A=2, B=4, Bin=1 → D=1101 (−3), Bout=1, V=0, Z=0.
- A=4'h8, B=1, Bin=0 → D=0111, Bout=0, V=1; then A=4'h7, B=4'hF, Bin=0 → D=1000, Bout=1, V=1.
- A=4'hB, B=4'hB, Bin=0 → D=0000, Z=1, Bout=0. Then A=0, B=0, Bin=1 → D=1111, Bout=1, V=0, Z=0.
- Handshake/abort:
  - start pulsed again and A/B changed during SHIFT → ignored; result is from the original operands.
  - rst during 2nd SHIFT cycle → no done, outputs 0.
  - start held high continuously → completions every 6 cycles.
